booth_seq_ctrl: RTL

- Control unit for the sequential radix-2 Booth multiplier.
- Accepts a multiply request through a valid/ready handshake and sequences the datapath (load, add/sub, arithmetic shift) for WIDTH iterations.
- Owns the iteration counter and its terminal-count detection; the comparator only flags terminal count, this block acts on it.
- Presents completion through a valid/ready result handshake.

---
 rtl/booth_seq_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/booth_seq_ctrl.sv
// Control unit for a sequential radix-2 Booth multiplier: accepts a request,
// steps the datapath through WIDTH eval/shift iterations and hands off the product.
module booth_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             q_lsb,
  input  logic             q_m1,
  output logic             load,
  output logic             add,
  output logic             sub,
  output logic             shift,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid holds its value until that edge, ready may be
  // asserted independently and is never derived from valid.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] count_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    count_nx    = count;
    start_ready = 1'b0;
    load        = 1'b0;
    add         = 1'b0;
    sub         = 1'b0;
    shift       = 1'b0;
    res_valid   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nx = LOAD;
      end
      LOAD: begin
        load     = 1'b1;
        count_nx = '0;
        state_nx = EVAL;
      end
      EVAL: begin
        // Booth recoding of the bit pair {Q[0],Q[-1]}: 10 subtracts, 01 adds.
        sub      = q_lsb & ~q_m1;
        add      = ~q_lsb & q_m1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (count == LAST) begin
          count_nx = '0;
          state_nx = DONE;
        end else begin
          count_nx = count + 1'b1;
          state_nx = EVAL;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
